// File: rtl/acc_alu_seq.sv
// Sequential accumulator ALU: a three-state FSM drives an external 8-bit adder.
// The accumulator and flags are written only on the edge that leaves EXEC.
module acc_alu_seq #(
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] operand,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_sub,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n,
  output logic       flag_v,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [7:0] beff;

  // Adder inputs come straight from registers so they hold steady through EXEC.
  assign add_a   = acc_q;
  assign add_b   = opnd_q;
  assign add_sub = (state_q == EXEC) && (op_q == OP_SUB);
  assign beff    = opnd_q ^ {8{add_sub}};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          op_d    = op;
          opnd_d  = operand;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d = add_sum;
            c_d   = add_cout;
            z_d   = (add_sum == 8'h00);
            n_d   = add_sum[7];
            v_d   = (acc_q[7] == beff[7]) && (add_sum[7] != acc_q[7]);
          end
          OP_LOAD: begin
            acc_d = opnd_q;
            z_d   = (opnd_q == 8'h00);
            n_d   = opnd_q[7];
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
          default: begin
            acc_d = 8'h00;
            z_d   = 1'b1;
            n_d   = 1'b0;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      opnd_q  <= 8'h00;
      acc_q   <= ACC_RESET;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign acc    = acc_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq; models the external adder the block drives.
module tb_acc_alu_seq;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] op;
  logic [7:0] operand;
  logic [7:0] add_a, add_b, add_sum, acc;
  logic       add_sub, add_cout;
  logic       flag_z, flag_c, flag_n, flag_v, busy, done;
  int total = 0;
  int bad   = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  always #5 clk = ~clk;

  // External adder: A + (B ^ sub) + sub; carry-out 1 on subtract means no borrow.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {8{add_sub}}} + {8'h00, add_sub};

  acc_alu_seq #(.ACC_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .operand(operand),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_sum(add_sum), .add_cout(add_cout),
    .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .busy(busy), .done(done)
  );

  // Issue one op and return at the negedge after done went high.
  task automatic run_op(input logic [1:0] o, input logic [7:0] d);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; operand = d;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL run_op_timeout: done never seen for op=%0d operand=%h", o, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = LOAD; operand = 8'h5A;
    repeat (2) @(negedge clk);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, busy, done, add_sub} !== 15'h0) begin
      bad++;
      $display("FAIL reset_state: acc=%h zcnv=%b%b%b%b busy=%b done=%b sub=%b, want all 0",
               acc, flag_z, flag_c, flag_n, flag_v, busy, done, add_sub);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || acc !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold_start: busy=%b acc=%h, want 0/00", busy, acc);
    end
  endtask

  task automatic test_load();
    run_op(LOAD, 8'h00);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h00, 4'b1000}) begin
      bad++;
      $display("FAIL load_zero: acc=%h zcnv=%b%b%b%b, want 00 1000", acc, flag_z, flag_c, flag_n, flag_v);
    end
    run_op(LOAD, 8'h7F);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h7F, 4'b0000}) begin
      bad++;
      $display("FAIL load_7f: acc=%h zcnv=%b%b%b%b, want 7f 0000", acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  // ADD 01 onto 7F with cycle-accurate latency and operand latching checks.
  task automatic test_add_overflow();
    @(negedge clk);
    start = 1'b1; op = ADD; operand = 8'h01;
    @(negedge clk);
    start = 1'b0; op = CLR; operand = 8'h55;
    total++;
    if ({busy, done, acc, add_a, add_b, add_sub} !== {2'b10, 8'h7F, 8'h7F, 8'h01, 1'b0}) begin
      bad++;
      $display("FAIL add_exec: busy=%b done=%b acc=%h a=%h b=%h sub=%b, want 1 0 7f 7f 01 0",
               busy, done, acc, add_a, add_b, add_sub);
    end
    @(negedge clk);
    total++;
    if ({done, busy, acc, flag_z, flag_c, flag_n, flag_v} !== {2'b11, 8'h80, 4'b0011}) begin
      bad++;
      $display("FAIL add_done: done=%b busy=%b acc=%h zcnv=%b%b%b%b, want 1 1 80 0011",
               done, busy, acc, flag_z, flag_c, flag_n, flag_v);
    end
    @(negedge clk);
    total++;
    if ({done, busy, acc} !== {2'b00, 8'h80}) begin
      bad++;
      $display("FAIL add_idle: done=%b busy=%b acc=%h, want 0 0 80", done, busy, acc);
    end
  endtask

  task automatic test_sub();
    run_op(LOAD, 8'h05);
    @(negedge clk);
    start = 1'b1; op = SUB; operand = 8'h05;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (add_sub !== 1'b1 || add_b !== 8'h05) begin
      bad++;
      $display("FAIL sub_adder_ctl: sub=%b b=%h, want 1 05", add_sub, add_b);
    end
    @(negedge clk);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, add_sub} !== {8'h00, 4'b1100, 1'b0}) begin
      bad++;
      $display("FAIL sub_equal: acc=%h zcnv=%b%b%b%b sub=%b, want 00 1100 0",
               acc, flag_z, flag_c, flag_n, flag_v, add_sub);
    end
    run_op(LOAD, 8'h03);
    run_op(SUB, 8'h05);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'hFE, 4'b0010}) begin
      bad++;
      $display("FAIL sub_borrow: acc=%h zcnv=%b%b%b%b, want fe 0010", acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  // start held through busy and DONE must yield exactly one operation.
  task automatic test_back_to_back();
    int dones = 0;
    run_op(LOAD, 8'h01);
    @(negedge clk);
    start = 1'b1; op = ADD; operand = 8'hFF;
    @(negedge clk);
    op = LOAD; operand = 8'hAA;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy: busy=%b, want 1", busy);
    end
    @(negedge clk);
    total++;
    if ({done, acc, flag_z, flag_c, flag_n, flag_v} !== {1'b1, 8'h00, 4'b1100}) begin
      bad++;
      $display("FAIL b2b_result: done=%b acc=%h zcnv=%b%b%b%b, want 1 00 1100",
               done, acc, flag_z, flag_c, flag_n, flag_v);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 0 || acc !== 8'h00) begin
      bad++;
      $display("FAIL b2b_single: extra busy/done cycles=%0d acc=%h, want 0 00", dones, acc);
    end
  endtask

  task automatic test_sub_ovf_clr();
    run_op(LOAD, 8'h80);
    run_op(SUB, 8'h01);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h7F, 4'b0101}) begin
      bad++;
      $display("FAIL sub_ovf: acc=%h zcnv=%b%b%b%b, want 7f 0101", acc, flag_z, flag_c, flag_n, flag_v);
    end
    run_op(CLR, 8'h99);
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v} !== {8'h00, 4'b1000}) begin
      bad++;
      $display("FAIL clr: acc=%h zcnv=%b%b%b%b, want 00 1000", acc, flag_z, flag_c, flag_n, flag_v);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    run_op(LOAD, 8'h80);
    @(negedge clk);
    start = 1'b1; op = ADD; operand = 8'h10;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({acc, flag_z, flag_c, flag_n, flag_v, busy, done} !== {8'h00, 6'b000000}) begin
      bad++;
      $display("FAIL abort_state: acc=%h zcnv=%b%b%b%b busy=%b done=%b, want 00 0000 0 0",
               acc, flag_z, flag_c, flag_n, flag_v, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || acc !== 8'h00) begin
      bad++;
      $display("FAIL abort_no_done: done cycles=%0d acc=%h, want 0 00", dones, acc);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = ADD; operand = 8'h00;
    test_reset();
    test_load();
    test_add_overflow();
    test_sub();
    test_back_to_back();
    test_sub_ovf_clr();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acc_alu_seq.md
ACC_ALU_SEQ -- requirements
Module: acc_alu_seq

Interface
REQ-001 SHALL have parameter ACC_RESET, default 8'h00: accumulator value loaded on reset.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have start  input  1  request to execute op; sampled only in IDLE.
REQ-005 SHALL have op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLR.
REQ-006 SHALL have operand  input  8  second operand / load value.
REQ-007 SHALL have add_a  output  8  to external 8-bit add/sub adder, operand A.
REQ-008 SHALL have add_b  output  8  to adder, operand B (uninverted; adder inverts on subtract).
REQ-009 SHALL have add_sub  output  1  to adder carry-in/subtract select; 1 = A-B.
REQ-010 SHALL have add_sum  input  8  adder result.
REQ-011 SHALL have add_cout  input  1  adder carry-out.
REQ-012 SHALL have acc  output  8  accumulator.
REQ-013 SHALL have flag_z, flag_c, flag_n, flag_v  output  1 each  zero, carry, negative, overflow flags.
REQ-014 SHALL have busy  output  1  high in EXEC and DONE.
REQ-015 SHALL have done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, DONE; IDLE->EXEC on start; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-017 SHALL latch op and operand into op_q/opnd_q on the edge accepting start; later changes to op/operand SHALL not affect the operation.
REQ-018 SHALL ignore start while busy=1 (EXEC, DONE); no queuing.
REQ-019 SHALL drive add_a=acc, add_b=opnd_q, add_sub=(op_q==SUB) combinationally from registers, stable throughout EXEC; add_sub=0 outside EXEC-with-SUB.
REQ-020 SHALL, on the edge leaving EXEC, write acc and flags per op_q; acc and flags SHALL not change at any other edge except reset.
REQ-021 ADD/SUB SHALL set acc=add_sum, flag_c=add_cout (SUB: 1 = no borrow), flag_z=(add_sum==0), flag_n=add_sum[7].
REQ-022 ADD/SUB SHALL set flag_v=(acc[7]==beff[7]) && (add_sum[7]!=acc[7]), beff=opnd_q XOR {8{add_sub}}, acc being the pre-write value.
REQ-023 LOAD SHALL set acc=opnd_q, flag_z=(opnd_q==0), flag_n=opnd_q[7], flag_c=0, flag_v=0; adder outputs ignored.
REQ-024 CLR SHALL set acc=0, flag_z=1, flag_n=0, flag_c=0, flag_v=0.
REQ-025 SHALL assert done only in DONE, exactly one cycle; latency start-accept edge t -> acc updated at edge t+1 -> done high during cycle after t+1.
REQ-026 Arithmetic SHALL wrap modulo 256; no saturation.
REQ-027 A start asserted in the cycle done is high SHALL be ignored; next start accepted in IDLE the following cycle.

Reset
REQ-028 reset SHALL force IDLE, acc=ACC_RESET, all flags 0, busy=0, done=0, op_q/opnd_q=0 at the next edge, overriding start.
REQ-029 reset during EXEC or DONE SHALL abort: no acc/flag write, no done pulse.

Verification
REQ-030 Reset 2 cycles -> acc=00, z/c/n/v=0, busy=0, done=0.
REQ-031 LOAD 7F then ADD 01 -> acc=80, n=1, v=1, c=0, z=0; done exactly 2 cycles after ADD start edge.
REQ-032 LOAD 05 then SUB 05 -> acc=00, z=1, c=1, v=0, n=0; LOAD 03 then SUB 05 -> acc=FE, c=0, n=1, v=0.
REQ-033 LOAD 01, ADD FF with start held high plus start pulses during busy -> single op, acc=00, c=1, z=1; no second done.
REQ-034 LOAD 80, SUB 01 -> acc=7F, v=1, c=1, n=0; then CLR -> acc=00, z=1, others 0.
REQ-035 ADD 10 started, reset asserted in EXEC -> acc=00, flags 0, no done, busy=0 next cycle.
